// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: round-robin between ALU and load writeback,
// plus a per-register pending scoreboard queried by decode for stall decisions.
module wb_arbiter #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_alu_valid,
    output logic                  o_alu_ready,
    input  logic [REG_ADDR_W-1:0] i_alu_addr,
    input  logic [DATA_W-1:0]     i_alu_data,
    input  logic                  i_ld_valid,
    output logic                  o_ld_ready,
    input  logic [REG_ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0]     i_ld_data,
    input  logic                  i_issue_en,
    input  logic [REG_ADDR_W-1:0] i_issue_addr,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy,
    output logic                  o_rd_busy,
    output logic                  o_we,
    output logic [REG_ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0]     o_wdata
);

    logic [NUM_REGS-1:0]   r_pending;
    logic                  r_last_grant;  // 0 = ALU, 1 = LD
    logic                  r_we;
    logic [REG_ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0]     r_wdata;

    logic                  w_grant_alu;
    logic                  w_grant_ld;
    logic                  w_accept;
    logic                  w_commit;
    logic [REG_ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0]     w_acc_data;
    logic [NUM_REGS-1:0]   w_pending_d;

    // Under contention the source that did not win last time is granted.
    assign w_grant_alu = !rst && i_alu_valid && (!i_ld_valid || r_last_grant);
    assign w_grant_ld  = !rst && i_ld_valid && (!i_alu_valid || !r_last_grant);
    assign w_accept    = w_grant_alu || w_grant_ld;
    assign w_acc_addr  = w_grant_ld ? i_ld_addr : i_alu_addr;
    assign w_acc_data  = w_grant_ld ? i_ld_data : i_alu_data;
    assign w_commit    = w_accept && (w_acc_addr != '0);

    assign o_alu_ready = w_grant_alu;
    assign o_ld_ready  = w_grant_ld;

    // Clear before set so a same-edge issue to the committing register keeps it pending.
    always_comb begin
        w_pending_d = r_pending;
        if (w_commit) begin
            w_pending_d[w_acc_addr] = 1'b0;
        end
        if (i_issue_en && (i_issue_addr != '0)) begin
            w_pending_d[i_issue_addr] = 1'b1;
        end
        w_pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= '0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
        end else begin
            r_pending <= w_pending_d;
            r_we      <= w_commit;
            if (w_accept) begin
                r_last_grant <= w_grant_ld;
            end
            if (w_commit) begin
                r_waddr <= w_acc_addr;
                r_wdata <= w_acc_data;
            end
        end
    end

    // The regfile bypasses the write in flight, so that register is not busy.
    assign o_rs1_busy = r_pending[i_rs1_addr] && !(r_we && (r_waddr == i_rs1_addr));
    assign o_rs2_busy = r_pending[i_rs2_addr] && !(r_we && (r_waddr == i_rs2_addr));
    assign o_rd_busy  = r_pending[i_rd_addr] && !(r_we && (r_waddr == i_rd_addr));

    assign o_we    = r_we;
    assign o_waddr = r_waddr;
    assign o_wdata = r_wdata;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural scoreboard model.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rs1_busy, rs2_busy, rd_busy;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    wb_arbiter #(
        .REG_ADDR_W(5),
        .NUM_REGS  (32),
        .DATA_W    (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_alu_valid (alu_valid),
        .o_alu_ready (alu_ready),
        .i_alu_addr  (alu_addr),
        .i_alu_data  (alu_data),
        .i_ld_valid  (ld_valid),
        .o_ld_ready  (ld_ready),
        .i_ld_addr   (ld_addr),
        .i_ld_data   (ld_data),
        .i_issue_en  (issue_en),
        .i_issue_addr(issue_addr),
        .i_rs1_addr  (rs1_addr),
        .i_rs2_addr  (rs2_addr),
        .i_rd_addr   (rd_addr),
        .o_rs1_busy  (rs1_busy),
        .o_rs2_busy  (rs2_busy),
        .o_rd_busy   (rd_busy),
        .o_we        (we),
        .o_waddr     (waddr),
        .o_wdata     (wdata)
    );

    always #5 clk = ~clk;

    // Behavioural model: a bit per register, who won last, and the write port contents.
    bit        m_pend [32];
    bit        m_last_ld;
    bit        m_we;
    bit [4:0]  m_waddr;
    bit [31:0] m_wdata;

    // 0 = nobody, 1 = ALU, 2 = LD
    function automatic int model_grant();
        if (rst) return 0;
        if (alu_valid && ld_valid) return m_last_ld ? 1 : 2;
        if (alu_valid) return 1;
        if (ld_valid) return 2;
        return 0;
    endfunction

    function automatic bit model_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        return m_pend[a] && !(m_we && (m_waddr == a));
    endfunction

    always @(posedge clk) begin
        int        g;
        bit [4:0]  a;
        bit [31:0] d;
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_last_ld = 1'b1;
            m_we      = 1'b0;
            m_waddr   = '0;
            m_wdata   = '0;
        end else begin
            g    = model_grant();
            m_we = 1'b0;
            if (g != 0) begin
                a         = (g == 1) ? alu_addr : ld_addr;
                d         = (g == 1) ? alu_data : ld_data;
                m_last_ld = (g == 2);
                if (a != 5'd0) begin
                    m_we      = 1'b1;
                    m_waddr   = a;
                    m_wdata   = d;
                    m_pend[a] = 1'b0;
                end
            end
            if (issue_en && issue_addr != 5'd0) m_pend[issue_addr] = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int g;
        if (chk_en) begin
            g = model_grant();
            check("alu_ready", 32'(alu_ready), 32'(g == 1));
            check("ld_ready", 32'(ld_ready), 32'(g == 2));
            check("we", 32'(we), 32'(m_we));
            check("waddr", 32'(waddr), 32'(m_waddr));
            check("wdata", wdata, m_wdata);
            check("rs1_busy", 32'(rs1_busy), 32'(model_busy(rs1_addr)));
            check("rs2_busy", 32'(rs2_busy), 32'(model_busy(rs2_addr)));
            check("rd_busy", 32'(rd_busy), 32'(model_busy(rd_addr)));
        end
    end

    task automatic idle();
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0;
        issue_en = 0; issue_addr = 0;
        rs1_addr = 0; rs2_addr = 0; rd_addr = 0;
    endtask

    task automatic to_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit a_acc, l_acc, was_rst;
        rst = 1'b1;
        idle();
        to_pos();
        chk_en = 1'b1;

        // Reset state while both sources request
        alu_valid = 1; ld_valid = 1;
        to_neg();
        check("rst_alu_ready", 32'(alu_ready), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        to_pos();
        rst = 0;

        // Single ALU write
        idle();
        alu_valid = 1; alu_addr = 5; alu_data = 32'h11;
        to_neg();
        check("t1_alu_ready", 32'(alu_ready), 32'd1);
        check("t1_ld_ready0", 32'(ld_ready), 32'd0);
        to_pos();
        alu_valid = 0;
        to_neg();
        check("t1_we", 32'(we), 32'd1);
        check("t1_waddr", 32'(waddr), 32'd5);
        check("t1_wdata", wdata, 32'h11);
        check("t1_ld_ready1", 32'(ld_ready), 32'd0);
        to_pos();

        // Continuous contention after a one-cycle reset
        rst = 1;
        to_pos();
        rst = 0;
        alu_valid = 1; alu_addr = 1; alu_data = 32'hA1;
        ld_valid = 1; ld_addr = 2; ld_data = 32'hB2;
        for (int i = 0; i < 5; i++) begin
            to_neg();
            if (i < 4) begin
                check("t2_alu_ready", 32'(alu_ready), 32'((i % 2) == 0));
                check("t2_ld_ready", 32'(ld_ready), 32'((i % 2) == 1));
            end
            if (i > 0) begin
                check("t2_we", 32'(we), 32'd1);
                check("t2_waddr", 32'(waddr), ((i - 1) % 2 == 0) ? 32'd1 : 32'd2);
            end
            to_pos();
            if (i == 3) begin
                alu_valid = 0; ld_valid = 0;
            end
        end

        // Issue x7, then a load to x7 retires it
        idle();
        issue_en = 1; issue_addr = 7;
        to_pos();
        issue_en = 0; rs1_addr = 7;
        to_neg();
        check("t3_busy_set", 32'(rs1_busy), 32'd1);
        to_pos();
        ld_valid = 1; ld_addr = 7; ld_data = 32'h77;
        to_neg();
        check("t3_ld_ready", 32'(ld_ready), 32'd1);
        to_pos();
        ld_valid = 0;
        to_neg();
        check("t3_we", 32'(we), 32'd1);
        check("t3_busy_masked", 32'(rs1_busy), 32'd0);
        to_pos();
        to_neg();
        check("t3_busy_cleared", 32'(rs1_busy), 32'd0);
        to_pos();

        // Same-edge issue and commit to x3: the issue wins
        idle();
        alu_valid = 1; alu_addr = 3; alu_data = 32'h33;
        issue_en = 1; issue_addr = 3; rd_addr = 3;
        to_neg();
        check("t4_alu_ready", 32'(alu_ready), 32'd1);
        to_pos();
        alu_valid = 0; issue_en = 0;
        to_neg();
        check("t4_we", 32'(we), 32'd1);
        check("t4_rd_masked", 32'(rd_busy), 32'd0);
        to_pos();
        to_neg();
        check("t4_rd_busy", 32'(rd_busy), 32'd1);
        to_pos();

        // Register 0 writes and issues are no-ops
        idle();
        alu_valid = 1; alu_addr = 0; alu_data = 32'hFF;
        issue_en = 1; issue_addr = 0;
        to_neg();
        check("t5_alu_ready", 32'(alu_ready), 32'd1);
        to_pos();
        idle();
        to_neg();
        check("t5_we", 32'(we), 32'd0);
        check("t5_rs1", 32'(rs1_busy), 32'd0);
        check("t5_rs2", 32'(rs2_busy), 32'd0);
        check("t5_rd", 32'(rd_busy), 32'd0);
        to_pos();

        // Fill the scoreboard, then reset with a write in flight
        for (int a = 1; a < 32; a++) begin
            issue_en = 1; issue_addr = 5'(a);
            if (a == 31) begin
                alu_valid = 1; alu_addr = 9; alu_data = 32'h99;
            end
            to_pos();
        end
        issue_en = 0;
        rst = 1;
        alu_valid = 1; alu_addr = 4; alu_data = 32'h44;
        ld_valid = 1; ld_addr = 6; ld_data = 32'h66;
        rs1_addr = 31;
        to_neg();
        check("t6_rst_alu_ready", 32'(alu_ready), 32'd0);
        check("t6_rst_ld_ready", 32'(ld_ready), 32'd0);
        check("t6_pre_busy", 32'(rs1_busy), 32'd1);
        to_pos();
        rst = 0;
        rs1_addr = 5; rs2_addr = 31; rd_addr = 1;
        to_neg();
        check("t6_we", 32'(we), 32'd0);
        check("t6_rs1", 32'(rs1_busy), 32'd0);
        check("t6_rs2", 32'(rs2_busy), 32'd0);
        check("t6_rd", 32'(rd_busy), 32'd0);
        check("t6_alu_first", 32'(alu_ready), 32'd1);
        check("t6_ld_loses", 32'(ld_ready), 32'd0);
        to_pos();
        idle();

        // Randomized traffic; requesters hold until accepted
        for (int n = 0; n < 3000; n++) begin
            to_neg();
            a_acc   = alu_valid && alu_ready;
            l_acc   = ld_valid && ld_ready;
            was_rst = rst;
            to_pos();
            rst = ($urandom_range(0, 99) == 0);
            if (was_rst) begin
                alu_valid = 0; ld_valid = 0;
            end else begin
                if (!alu_valid || a_acc) begin
                    alu_valid = ($urandom_range(0, 9) < 6);
                    alu_addr  = 5'($urandom_range(0, 31));
                    alu_data  = $urandom;
                end
                if (!ld_valid || l_acc) begin
                    ld_valid = ($urandom_range(0, 9) < 5);
                    ld_addr  = 5'($urandom_range(0, 31));
                    ld_data  = $urandom;
                end
            end
            issue_en   = ($urandom_range(0, 2) == 0);
            issue_addr = 5'($urandom_range(0, 31));
            rs1_addr   = 5'($urandom_range(0, 31));
            rs2_addr   = 5'($urandom_range(0, 31));
            rd_addr    = 5'($urandom_range(0, 31));
        end

        to_neg();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Shares the single register-file write port between the ALU writeback path and the load-return path, and keeps a per-register pending scoreboard for the issue stage. Each cycle it grants at most one writeback requester by round-robin and registers the winning write onto the regfile write port. It sets pending bits when instructions issue, clears them when the matching write commits, and reports busy status for rs1/rs2/rd so decode can stall. It sits between the EX/MEM writeback sources and the regfile, beside the decode stall logic.

## Interface
- REG_ADDR_W, 5, register address width
- NUM_REGS, 32, number of architectural registers (2**REG_ADDR_W)
- DATA_W, 32, register data width

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_addr  in  REG_ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_valid  in  1  load writeback request
- ld_ready  out  1  load request accepted this cycle
- ld_addr  in  REG_ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- issue_en  in  1  instruction with a destination issues this cycle
- issue_addr  in  REG_ADDR_W  destination of the issuing instruction
- rs1_addr, rs2_addr, rd_addr  in  REG_ADDR_W  decode query addresses
- rs1_busy, rs2_busy, rd_busy  out  1  query result (combinational)
- we  out  1  regfile write enable (registered)
- waddr  out  REG_ADDR_W  regfile write address (registered)
- wdata  out  DATA_W  regfile write data (registered)

## Operation
- State: pending[NUM_REGS-1:0], last_grant (0=ALU, 1=LD), output registers we/waddr/wdata.
- Arbitration (combinational ready):
  - If only one source is valid, it is granted.
  - If both are valid, the source not equal to last_grant is granted.
  - If neither is valid, nothing is granted.
  - The losing source's ready is 0; it must hold valid/addr/data stable until accepted.
  - ready is never asserted without the corresponding valid.
- last_grant updates to the granted source only on a cycle with a grant.
- Accept (valid && ready) for a non-zero address: at the next edge, we=1, waddr=addr, wdata=data, and pending[addr] clears.
- Accept for address 0: the request is consumed (ready=1), we=0 next cycle, pending untouched.
- No grant: we=0 next cycle; waddr and wdata hold their previous values.
- Issue: issue_en with issue_addr!=0 sets pending[issue_addr] at the edge. issue_addr=0 is ignored. pending[0] is always 0.
- Same edge, same address, set and clear: set wins, because the new instruction owns the register.
- Busy queries:
  - x_busy = pending[x_addr] && !(we && waddr==x_addr).
  - The regfile bypasses same-cycle writes, so a register committing this cycle reports not busy.
  - Address 0 always reports 0.
- Issue stage rule: decode must not issue to a register whose rd_busy=1 (no WAW outstanding). The block does not check this.

## Timing
- Reset values: we=0, waddr=0, wdata=0, pending=0, last_grant=1 (ALU wins the first contended cycle). alu_ready=ld_ready=0 while rst=1.
- Reset mid-operation: all pending requests are dropped, an in-flight we is cleared at the reset edge, and requesters re-present after reset.
- Latency: accepted request to regfile write is 1 cycle (appears on we/waddr/wdata at the next edge; regfile commits on the edge after).
- Pending clear is visible in the cycle after acceptance. The busy query is also masked during the we cycle.
- Throughput: one write per cycle. Under continuous contention, grants alternate strictly ALU, LD, ALU, …
- Issue set is visible on *_busy in the cycle after issue_en.

## Test plan
- Reset, then alu_valid only, alu_addr=5, alu_data=0x11 -> alu_ready=1 that cycle; next cycle we=1, waddr=5, wdata=0x11; ld_ready=0 throughout.
- Both valid continuously for 4 cycles (ALU to x1, LD to x2, sources holding until accepted) -> grant order ALU, LD, ALU, LD; we high every cycle; waddr sequence 1, 2, 1, 2.
- issue_en to x7, then rs1_addr=7 -> rs1_busy=1. Load to x7 accepted -> during the we cycle rs1_busy=0; afterwards pending[7]=0.
- issue_en to x3 on the same cycle an ALU write to x3 is accepted -> pending[3]=1 after the edge; rd_busy(3)=1 once we drops.
- ALU write to x0 and issue_en to x0 -> alu_ready=1, we=0 next cycle, all busy outputs for address 0 read 0.
- Assert rst for 1 cycle while both sources are valid and pending=0xFFFFFFFE -> we=0, pending=0, readies 0 during reset; the first contended grant after reset goes to ALU.
